jtag_scan_master: RTL and testbench

// - Upstream host-side driver for the on-chip JTAG TAP controller.
// - Converts IR/DR scan commands on a valid/ready interface into TCK/TMS/TDI waveforms.
// - Captures TDO during each scan and returns it on a response handshake.
// - Replaces the fixed TMS sequencer for arbitrary scans. Runs on the system clock; TCK is derived internally.

---
 rtl/jtag_scan_master.sv | 197 +++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: host-side JTAG scan engine.
// Accepts IR/DR scan commands on a valid/ready interface, generates the
// TCK/TMS/TDI waveform from Run-Test/Idle back to Run-Test/Idle, and returns
// the captured TDO bits on a response handshake. TCK is derived from clk
// (half-period TCK_DIV clk cycles).
// Optional feature macro: JTAG_SCAN_MASTER_TLR_CMD_EN
//   defined   : IR command with length 0 walks the TAP through Test-Logic-Reset
//               (5 x TMS=1, 1 x TMS=0) and returns rsp_data=0.
//   undefined : that encoding is an ordinary zero-length command (no TCK).
module jtag_scan_master #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int TCK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  // FSM states
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Waveform flavour of the active sequence
  localparam logic [1:0] M_TLR = 2'd0;  // 5 x TMS=1 then TMS=0
  localparam logic [1:0] M_DR  = 2'd1;
  localparam logic [1:0] M_IR  = 2'd2;

  // Step counter is wide enough for the longest sequence (MAX_LEN+6 TCKs)
  // and for base+len arithmetic, so it never wraps.
  localparam int SW0 = $clog2(MAX_LEN + 7);
  localparam int CW  = ((SW0 > LEN_W) ? SW0 : LEN_W) + 1;
  localparam int DW  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DW-1:0]    DIV_LAST  = DW'(TCK_DIV - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [1:0]         state;
  logic [1:0]         mode;
  logic [LEN_W-1:0]   clen;
  logic [CW-1:0]      step;
  logic [DW-1:0]      div_cnt;
  logic [MAX_LEN-1:0] sdata;
  logic [MAX_LEN-1:0] bit_mask;

  logic [LEN_W-1:0]   clen_in;
  logic               tlr_cmd;
  logic               accept;
  logic               active;
  logic               tick;
  logic               rise;
  logic               fall;
  logic [CW-1:0]      len_c;
  logic [CW-1:0]      last_step;
  logic [CW-1:0]      nxt_step;
  logic               cur_shift;
  logic               nxt_shift;
  logic               nxt_tms;

  // First TCK index of the shift region: after 1,0,0 (DR) or 1,1,0,0 (IR)
  function automatic logic [CW-1:0] base_of(input logic [1:0] m);
    return (m == M_IR) ? CW'(4) : CW'(3);
  endfunction

  function automatic logic is_shift(input logic [1:0] m, input logic [CW-1:0] s,
                                    input logic [CW-1:0] len);
    return (m != M_TLR) && (s >= base_of(m)) && (s < base_of(m) + len);
  endfunction

  // TMS value for TCK number s of the sequence
  function automatic logic tms_at(input logic [1:0] m, input logic [CW-1:0] s,
                                  input logic [CW-1:0] len);
    logic [CW-1:0] b;
    b = base_of(m);
    if (m == M_TLR) return (s < CW'(5));
    if (s < b) return (m == M_IR) ? (s < CW'(2)) : (s == '0);
    if (s < b + len) return (s == b + len - CW'(1));
    return (s == b + len);
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign clen_in   = (cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;

`ifdef JTAG_SCAN_MASTER_TLR_CMD_EN
  assign tlr_cmd = cmd_ir && (clen_in == '0);
`else
  assign tlr_cmd = 1'b0;
`endif

  // TCK phase decode: tick marks the clk cycle in which tck toggles
  always_comb begin
    active    = (state == S_INIT) || (state == S_SCAN);
    tick      = active && (div_cnt == DIV_LAST);
    rise      = tick && !tck;
    fall      = tick && tck;
    len_c     = CW'(clen);
    last_step = (mode == M_TLR) ? CW'(5) : base_of(mode) + len_c + CW'(1);
    nxt_step  = step + CW'(1);
    cur_shift = is_shift(mode, step, len_c);
    nxt_shift = is_shift(mode, nxt_step, len_c);
    nxt_tms   = tms_at(mode, nxt_step, len_c);
  end

  // Control FSM and TCK/TMS/TDI sequencer; TMS/TDI only move when TCK falls,
  // and park at TMS=1/TDI=0 so the next sequence's first TCK needs no setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      mode    <= M_TLR;
      clen    <= '0;
      step    <= '0;
      div_cnt <= '0;
      tck     <= 1'b0;
      tms     <= 1'b1;
      tdi     <= 1'b0;
      sdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            clen    <= clen_in;
            sdata   <= cmd_data;
            step    <= '0;
            div_cnt <= '0;
            if (tlr_cmd) begin
              mode  <= M_TLR;
              state <= S_SCAN;
            end else if (clen_in == '0) begin
              state <= S_RESP;
            end else begin
              mode  <= cmd_ir ? M_IR : M_DR;
              state <= S_SCAN;
            end
          end
        end
        S_INIT, S_SCAN: begin
          if (tick) begin
            div_cnt <= '0;
            tck     <= !tck;
            if (fall) begin
              if (step == last_step) begin
                tms   <= 1'b1;
                tdi   <= 1'b0;
                state <= (state == S_INIT) ? S_IDLE : S_RESP;
              end else begin
                step <= nxt_step;
                tms  <= nxt_tms;
                if (nxt_shift) begin
                  tdi   <= sdata[0];
                  sdata <= sdata >> 1;
                end else begin
                  tdi <= 1'b0;
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // TDO capture: one-hot pointer walks up from bit 0, one step per shift TCK,
  // so bits at or above the latched length stay at their cleared value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      bit_mask <= '0;
    end else if (accept) begin
      rsp_data <= '0;
      bit_mask <= MAX_LEN'(1);
    end else if (state == S_SCAN && rise && cur_shift) begin
      rsp_data <= rsp_data | (bit_mask & {MAX_LEN{tdo}});
      bit_mask <= bit_mask << 1;
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: randomized self-checking bench for jtag_scan_master.
// A behavioural TAP (16-state FSM, 8-bit DR, 4-bit IR) sits on the JTAG pins.
// Expected TMS/TDI sequences, TCK counts, response data and the TAP's new
// register contents are computed from the scan rules with plain arithmetic.
module tb_jtag_scan_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_ir;
  logic [3:0] cmd_len;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       tck, tms, tdi;
  logic       tdo = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  jtag_scan_master #(.MAX_LEN(8), .LEN_W(4), .TCK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // ---------------- TAP model ----------------
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PAUDR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPDIR = 15;

  int         tap_st = SELIR;
  logic [7:0] dr_reg = 8'h06;
  logic [7:0] dr_sr  = 8'h00;
  logic [3:0] ir_reg = 4'hA;
  logic [3:0] ir_sr  = 4'h0;
  int         tck_total = 0;
  logic       tms_hist [0:4095];
  logic       tdi_hist [0:4095];

  always @(posedge tck) begin
    tms_hist[tck_total % 4096] = tms;
    tdi_hist[tck_total % 4096] = tdi;
    tck_total = tck_total + 1;
    case (tap_st)
      TLR:   tap_st = tms ? TLR : RTI;
      RTI:   tap_st = tms ? SELDR : RTI;
      SELDR: tap_st = tms ? SELIR : CAPDR;
      CAPDR: begin dr_sr = dr_reg; tap_st = tms ? EX1DR : SHDR; end
      SHDR:  begin dr_sr = {tdi, dr_sr[7:1]}; tap_st = tms ? EX1DR : SHDR; end
      EX1DR: tap_st = tms ? UPDDR : PAUDR;
      PAUDR: tap_st = tms ? EX2DR : PAUDR;
      EX2DR: tap_st = tms ? UPDDR : SHDR;
      UPDDR: tap_st = tms ? SELDR : RTI;
      SELIR: tap_st = tms ? TLR : CAPIR;
      CAPIR: begin ir_sr = ir_reg; tap_st = tms ? EX1IR : SHIR; end
      SHIR:  begin ir_sr = {tdi, ir_sr[3:1]}; tap_st = tms ? EX1IR : SHIR; end
      EX1IR: tap_st = tms ? UPDIR : PAUIR;
      PAUIR: tap_st = tms ? EX2IR : PAUIR;
      EX2IR: tap_st = tms ? UPDIR : SHIR;
      UPDIR: tap_st = tms ? SELDR : RTI;
      default: tap_st = TLR;
    endcase
    if (tap_st == UPDDR) dr_reg = dr_sr;
    if (tap_st == UPDIR) ir_reg = ir_sr;
  end

  always @(negedge tck) begin
    tdo = (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;
  end

  // TMS/TDI may only move in the clk cycle where TCK falls
  int   viol = 0;
  logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0, p_rst = 1'b0;
  always @(negedge clk) begin
    if (rst_n && p_rst && ((tms !== p_tms) || (tdi !== p_tdi)) && !(p_tck && !tck))
      viol = viol + 1;
    p_tck = tck; p_tms = tms; p_tdi = tdi; p_rst = rst_n;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hist_word(input int s, input int n, input bit sel_tdi);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n && k < 32; k++)
      w[k] = sel_tdi ? tdi_hist[(s + k) % 4096] : tms_hist[(s + k) % 4096];
    return w;
  endfunction

  // Release reset and expect INIT: 6 TCK with TMS 1,1,1,1,1,0 ending in RTI
  task automatic init_check(input string tag);
    int start, n;
    start = tck_total;
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, cmd_ready, 1'b1);
    chk({tag, "_tck"}, tck_total - start, 6);
    chk({tag, "_tms"}, hist_word(start, 6, 1'b0), 32'h1F);
    chk({tag, "_tdi"}, hist_word(start, 6, 1'b1), 32'h0);
    chk({tag, "_tap"}, tap_st, RTI);
  endtask

  task automatic run_cmd(input logic ir, input logic [3:0] len, input logic [7:0] data,
                         input int hold);
    int          eff, npre, n, start, mid, bad, e_cnt;
    logic        tlr;
    logic [31:0] e_tms, e_tdi;
    logic [63:0] comb, mask;
    logic [7:0]  e_rsp, r0, dm, e_dr;
    logic [3:0]  e_ir;
    eff = (len > 4'd8) ? 8 : int'(len);
    tlr = 1'b0;
`ifdef JTAG_SCAN_MASTER_TLR_CMD_EN
    tlr = ir && (eff == 0);
`endif
    e_tms = '0; e_tdi = '0; e_cnt = 0; e_rsp = '0; e_dr = dr_reg; e_ir = ir_reg;
    if (tlr) begin
      e_tms = 32'h1F; e_cnt = 6;
    end else if (eff > 0) begin
      npre = ir ? 4 : 3;
      e_tms[0] = 1'b1;
      if (ir) e_tms[1] = 1'b1;
      for (int i = 0; i < eff; i++) e_tdi[npre + i] = data[i];
      e_tms[npre + eff - 1] = 1'b1;
      e_tms[npre + eff]     = 1'b1;
      e_cnt = npre + eff + 2;
      mask  = (64'd1 << eff) - 64'd1;
      dm    = data & 8'(mask);
      if (ir) begin
        comb  = (64'(dm) << 4) | 64'(ir_reg);
        e_rsp = 8'(comb & mask);
        e_ir  = 4'(comb >> eff);
      end else begin
        comb  = (64'(dm) << 8) | 64'(dr_reg);
        e_rsp = 8'(comb & mask);
        e_dr  = 8'(comb >> eff);
      end
    end
    start = tck_total;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_len = len; cmd_data = data;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_ir = 1'($urandom); cmd_len = 4'($urandom); cmd_data = 8'($urandom);
    if (eff == 0 && !tlr) chk("len0_lat", {rsp_valid, rsp_data}, {1'b1, 8'h00});
    else                  chk("busy", {rsp_valid, cmd_ready}, 2'b00);
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    chk("rsp_valid", rsp_valid, 1'b1);
    r0 = rsp_data; bad = 0; mid = tck_total;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      if (!rsp_valid || rsp_data !== r0 || cmd_ready) bad++;
    end
    if (hold > 0) begin
      chk("hold_stable", bad, 0);
      chk("hold_no_tck", tck_total - mid, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("rsp_data", rsp_data, e_rsp);
    chk("tck_cnt", tck_total - start, e_cnt);
    chk("tms_seq", hist_word(start, e_cnt, 1'b0), e_tms);
    chk("tdi_seq", hist_word(start, e_cnt, 1'b1), e_tdi);
    chk("tap_rti", tap_st, RTI);
    chk("tap_dr", dr_reg, e_dr);
    chk("tap_ir", ir_reg, e_ir);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ir = 1'b0; cmd_len = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", {tck, tms, tdi, cmd_ready, rsp_valid, rsp_data},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    init_check("init");

    run_cmd(1'b0, 4'd4, 8'b0000_1011, 0);   // DR len 4 against DR preload 0x06
    run_cmd(1'b1, 4'd4, 8'b0000_0001, 0);   // IR len 4 -> IR=0001
    run_cmd(1'b0, 4'd8, 8'hA5, 20);         // response stalled 20 clk
    run_cmd(1'b0, 4'd0, 8'hFF, 0);          // zero length
    run_cmd(1'b0, 4'd15, 8'h3C, 1);         // clamped to 8
    run_cmd(1'b1, 4'd0, 8'h55, 0);          // IR len 0 (TLR command when enabled)

    // Reset in the 3rd shift TCK of an 8-bit DR scan
    start = tck_total;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = 1'b0; cmd_len = 4'd8; cmd_data = 8'hC3;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while ((tck_total - start) < 6 && n < 200) begin @(negedge clk); n++; end
    chk("mid_reach", tck_total - start, 6);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", {tck, tms, tdi, rsp_valid, cmd_ready, rsp_data},
           {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    repeat (3) @(negedge clk);
    init_check("reinit");

    for (int k = 0; k < 40; k++)
      run_cmd(1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
              int'($urandom_range(0, 3)));

    chk("edge_rule", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
